// File: rtl/clock_domain_import.sv
// Receiving end of a toggle req/ack clock-domain-crossing handshake.
// A foreign handshake_req is synchronised into the local clock. When a
// synchronised request differs from the returned ack, the word on
// handshake_data is captured into a small FIFO and the ack is toggled back.
// Local logic drains the FIFO through a stb/ready interface, so the sender
// can refill while the consumer stalls.
//
// Local stb/ready semantics: stb=1 means data holds the head-of-FIFO word.
// A word is consumed on a rising clk edge where stb=1 and ready=1, and the
// next word (or stb=0) is visible after that edge. ready is ignored while
// stb=0, and stb never depends combinationally on ready.
module clock_domain_import #(
  parameter int SIZE        = 8,
  parameter int DEPTH       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [SIZE-1:0] data,
  output logic            stb,
  input  logic            ready,
  input  logic [SIZE-1:0] handshake_data,
  input  logic            handshake_req,
  output logic            handshake_ack
);

  // Pointer width; DEPTH=1 keeps a 1-bit pointer that is held at 0.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Count holds 0..DEPTH inclusive.
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic                   pending;
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;

  logic [SIZE-1:0]        mem [DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [CW-1:0]          count;

  // Synchronise the foreign request; only the last stage is used by logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], handshake_req};
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  // Transfer bookkeeping. full/empty come from the registered count, so a
  // full FIFO never accepts a push on the same edge as a pop; the push then
  // happens one cycle later.
  always_comb begin
    pending = (req_s != handshake_ack);
    full    = (count == FULL_CNT);
    empty   = (count == '0);
    push    = pending && !full;
    pop     = !empty && ready;
  end

  // Return the ack only when the word has actually been captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      handshake_ack <= 1'b0;
    end else if (push) begin
      handshake_ack <= req_s;
    end
  end

  // FIFO storage; contents are not reset, data is masked while empty.
  // handshake_data is stable whenever pending=1, so it is sampled directly.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= handshake_data;
    end
  end

  // Write pointer advances on each captured word, wrapping at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
    end
  end

  // Read pointer advances on each consumed word, wrapping at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
    end else if (pop) begin
      rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
    end
  end

  // Occupancy: simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head-of-FIFO presentation; reads as zero when nothing is buffered.
  always_comb begin
    stb  = !empty;
    data = empty ? '0 : mem[rd_ptr];
  end

endmodule

// File: tb/tb_clock_domain_import.sv
// Bench for clock_domain_import (SIZE=8, DEPTH=2, SYNC_STAGES=2).
// Stimulus pushes each sent word into exp_q; a negedge monitor pops and
// compares whenever the DUT hands a word over (stb && ready), and keeps an
// independent occupancy model to catch acks issued while full.
module tb_clock_domain_import;

  localparam int SIZE  = 8;
  localparam int DEPTH = 2;
  localparam int SYNC  = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [SIZE-1:0] data;
  logic            stb;
  logic            ready = 1'b0;
  logic [SIZE-1:0] handshake_data = '0;
  logic            handshake_req = 1'b0;
  logic            handshake_ack;

  logic [SIZE-1:0] exp_q[$];
  int              n_checks = 0;
  int              n_fail   = 0;
  bit              sender_done;

  clock_domain_import #(
    .SIZE(SIZE), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data          (data),
    .stb           (stb),
    .ready         (ready),
    .handshake_data(handshake_data),
    .handshake_req (handshake_req),
    .handshake_ack (handshake_ack)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  int mcount;
  bit last_ack;
  bit last_pop;
  always @(negedge clk) begin
    logic [SIZE-1:0] e;
    bit pushed;
    if (!rst_n) begin
      mcount   = 0;
      last_ack = 1'b0;
      last_pop = 1'b0;
    end else begin
      pushed = (handshake_ack != last_ack);
      if (pushed) check("ack_not_while_full", (mcount == DEPTH), 0);
      mcount = mcount + int'(pushed) - int'(last_pop);
      check("stb_vs_occupancy", stb, (mcount != 0));
      if (stb && ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("data_order", data, e);
        end
      end
      last_pop = stb && ready;
      last_ack = handshake_ack;
    end
  end

  // ---------------- driver tasks ----------------
  // Wait (bounded) until the sender may issue a new word.
  task automatic wait_ack(input string name);
    int n = 0;
    while (handshake_ack != handshake_req && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, handshake_ack, handshake_req);
  endtask

  // Clock-aligned send: new word lands just after a posedge.
  task automatic send_aligned(input logic [SIZE-1:0] d);
    @(posedge clk);
    #1;
    handshake_data = d;
    handshake_req  = ~handshake_req;
    exp_q.push_back(d);
  endtask

  // Bounded wait for the FIFO and scoreboard to drain.
  task automatic wait_drain(input string name);
    int n = 0;
    while ((stb || exp_q.size() != 0) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, (stb || exp_q.size() != 0), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset applied between clock edges takes effect with no edge.
    #2 rst_n = 1'b0;
    #1;
    check("reset_stb", stb, 0);
    check("reset_ack", handshake_ack, 0);
    check("reset_data", data, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single word latency: req toggles before edge N.
    ready = 1'b1;
    send_aligned(8'hA5);
    @(posedge clk);                 // N
    @(posedge clk); #1;             // N+1
    check("lat_ack_n1", handshake_ack, 0);
    check("lat_stb_n1", stb, 0);
    @(posedge clk); #1;             // N+2
    check("lat_ack_n2", handshake_ack, 1);
    check("lat_stb_n2", stb, 1);
    check("lat_data_n2", data, 8'hA5);
    @(posedge clk); #1;             // N+3
    check("lat_stb_n3", stb, 0);

    // Fill with the consumer stalled.
    ready = 1'b0;
    send_aligned(8'h11);
    wait_ack("fill_ack1");
    send_aligned(8'h22);
    wait_ack("fill_ack2");
    send_aligned(8'h33);
    repeat (6) @(posedge clk);
    #1;
    check("fill_ack3_held", (handshake_ack == handshake_req), 0);
    check("fill_stb", stb, 1);
    check("fill_head", data, 8'h11);
    ready = 1'b1;
    @(posedge clk); #1;             // first pop edge
    check("fill_ack3_at_pop", (handshake_ack == handshake_req), 0);
    @(posedge clk); #1;             // one cycle later
    check("fill_ack3_after_pop", (handshake_ack == handshake_req), 1);
    wait_drain("fill_drain");

    // Concurrent push/pop with one word buffered.
    ready = 1'b0;
    send_aligned(8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("cc_prefill_stb", stb, 1);
    check("cc_prefill_data", data, 8'h00);
    for (int i = 1; i < 16; i++) begin
      send_aligned(SIZE'(i));       // lands before edge M
      @(posedge clk);               // M
      @(posedge clk); #1;           // M+1
      ready = 1'b1;
      @(posedge clk); #1;           // M+2: push and pop together
      ready = 1'b0;
      check("cc_ack", handshake_ack, handshake_req);
      check("cc_stb", stb, 1);
      check("cc_head", data, SIZE'(i));
    end
    ready = 1'b1;
    wait_drain("cc_drain");

    // Reset while the sender holds req=1.
    @(posedge clk); #1;
    ready = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    handshake_req  = 1'b1;
    handshake_data = 8'h5C;
    #1;
    check("rst_mid_stb", stb, 0);
    check("rst_mid_ack", handshake_ack, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.push_back(8'h5C);
    @(posedge clk);                 // R1
    @(posedge clk); #1;             // R2
    check("rstreq_ack_r2", handshake_ack, 0);
    @(posedge clk); #1;             // R3 = SYNC_STAGES+1 edges
    check("rstreq_ack_r3", handshake_ack, 1);
    check("rstreq_stb", stb, 1);
    check("rstreq_data", data, 8'h5C);
    ready = 1'b1;
    wait_drain("rstreq_drain");
    repeat (5) @(posedge clk);
    #1;
    check("rstreq_single_word", stb, 0);
    check("rstreq_ack_kept", handshake_ack, 1);

    // Asynchronous sender at several rate ratios, random consumer.
    sender_done = 1'b0;
    fork
      begin : sender
        int lo, hi, n;
        for (int w = 0; w < 1000; w++) begin
          if (w < 333) begin lo = 1;  hi = 5;  end       // fast sender
          else if (w < 666) begin lo = 25; hi = 40; end  // slow sender
          else begin lo = 9;  hi = 11; end               // near 1:1, skewed
          n = 0;
          while (handshake_ack != handshake_req && n < 2000) begin
            #1;
            n++;
          end
          if (n >= 2000) begin
            check("rand_sender_ack_timeout", 1, 0);
            break;
          end
          #($urandom_range(hi, lo));
          handshake_data = SIZE'($urandom_range(255, 0));
          handshake_req  = ~handshake_req;
          exp_q.push_back(handshake_data);
        end
        sender_done = 1'b1;
      end
      begin : consumer
        int n = 0;
        while ((!sender_done || exp_q.size() != 0) && n < 60000) begin
          @(posedge clk);
          #1;
          ready = ($urandom_range(1, 0) == 1);
          n++;
        end
        ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    check("rand_all_words_seen", exp_q.size(), 0);
    check("rand_final_stb", stb, 0);
    check("rand_final_ack", handshake_ack, handshake_req);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
